video_timing_gen: RTL and testbench
===================================

VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 The block SHALL have parameter DE_O_PERIOD, default 0, meaning valid-pixel spacing: 0 or 1 gives a pixel every cycle, N>1 gives 1 valid cycle then N-1 empty cycles per pixel.
REQ-002 The block SHALL have parameter LINE_SIZE_MAX, default 1024, meaning the maximum pixels per line.
REQ-003 The block SHALL have parameter LINE_COUNT_MAX, default 1024, meaning the maximum lines per frame.
REQ-004 The block SHALL have parameter DATA_WIDTH, default 12, meaning the pixel width.
REQ-005 clk  input  1  the single clock; all logic on its rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 enable  input  1  run request, sampled only at frame boundaries.
REQ-008 pix_count  input  $clog2(LINE_SIZE_MAX+1)  active pixels per line, legal range 1..LINE_SIZE_MAX.
REQ-009 line_count  input  $clog2(LINE_COUNT_MAX+1)  active lines per frame, legal range 1..LINE_COUNT_MAX.
REQ-010 hblank  input  16  idle cycles between lines, minimum 1.
REQ-011 vblank  input  16  idle cycles between frames, minimum 1.
REQ-012 pattern  input  2  pattern select: 0 constant, 1 horizontal ramp, 2 vertical ramp, 3 checkerboard (8x8).
REQ-013 const_val  input  DATA_WIDTH  value used for pattern 0.
REQ-014 do_o  output  DATA_WIDTH  pixel data, registered.
REQ-015 de_o / hs_o / vs_o  output  1 each  data valid; hs high outside the active part of a line; vs high while the frame is active.
REQ-016 busy  output  1  high from frame start through the end of the frame's vblank.

Function
REQ-017 The FSM SHALL have states IDLE, ACTIVE, HBLANK and VBLANK.
REQ-018 Transitions SHALL be: IDLE->ACTIVE when enable=1; ACTIVE->HBLANK after the last pixel of a line; HBLANK->ACTIVE after hblank cycles if lines remain; HBLANK->VBLANK after hblank cycles of the last line; VBLANK->ACTIVE when enable=1 after vblank cycles, otherwise VBLANK->IDLE.
REQ-019 pix_count, line_count, hblank, vblank, pattern and const_val SHALL be latched at each IDLE->ACTIVE or VBLANK->ACTIVE transition, and SHALL be ignored mid-frame.
REQ-020 ACTIVE SHALL last pix_count*max(DE_O_PERIOD,1) cycles, with de_o=1 on the first cycle of each period.
REQ-021 hs_o SHALL be 0 throughout ACTIVE and 1 in all other states.
REQ-022 vs_o SHALL be 1 from the first ACTIVE cycle of line 0 through the last HBLANK cycle of the last line, and 0 in VBLANK and IDLE.
REQ-023 Outputs SHALL be registered, with all outputs of a cycle aligned to each other and a fixed one-cycle latency from the state decision.
REQ-024 do_o SHALL be valid when de_o=1 and SHALL hold its value when de_o=0.
REQ-025 Pattern 1 SHALL give do_o = x mod 2^DATA_WIDTH, where x is the pixel index within the line.
REQ-026 Pattern 2 SHALL give do_o = y mod 2^DATA_WIDTH, where y is the line index.
REQ-027 Pattern 3 SHALL give do_o = all ones when x[3]^y[3]=1, else 0.
REQ-028 The pixel and line counters SHALL wrap to 0 at the end of each line and each frame respectively, with no overflow beyond the latched counts.
REQ-029 A value of 0 for pix_count or line_count SHALL be treated as 1.
REQ-030 A value of 0 for hblank or vblank SHALL be treated as 1.
REQ-031 Deasserting enable mid-frame SHALL NOT truncate the frame; the frame SHALL complete, including vblank.

Reset
REQ-032 While rst=1 the FSM SHALL be in IDLE, all counters 0, and do_o=0, de_o=0, hs_o=1, vs_o=0, busy=0.
REQ-033 Reset asserted mid-frame SHALL abort immediately with no partial-line recovery; after release the block SHALL wait in IDLE for enable.

Configuration
REQ-034 With macro VIDEO_TIMING_GEN_FRAME_CNT_EN defined, a 16-bit frame counter SHALL increment at each VBLANK->ACTIVE/IDLE exit and SHALL be added (mod 2^DATA_WIDTH) to the ramp value of patterns 1 and 2 (moving ramp).
REQ-035 With VIDEO_TIMING_GEN_FRAME_CNT_EN defined, an output frame_cnt[15:0] SHALL be present, with reset value 0.
REQ-036 Without VIDEO_TIMING_GEN_FRAME_CNT_EN, the counter and the frame_cnt port SHALL be absent, and ramps SHALL start at 0 every frame.

Verification
REQ-037 DE_O_PERIOD=0, pix=4, lines=3, hblank=2, vblank=3, pattern=1 -> 3 lines of do_o 0,1,2,3 with de_o contiguous and hs_o=0 for exactly 4 cycles; vs_o high for 18 cycles.
REQ-038 DE_O_PERIOD=4, pix=3, pattern=2 -> ACTIVE lasts 12 cycles, de_o pulses on cycles 0,4,8, and do_o equals the line index.
REQ-039 pattern=3, pix=16, lines=16 -> pixel (8,0)=all ones, (8,8)=0, (0,0)=0.
REQ-040 enable dropped during line 1 of 3 -> the frame completes, then the FSM enters IDLE with busy=0 after vblank; enable reasserted -> the new frame starts with the newly latched parameters.
REQ-041 rst pulsed mid-ACTIVE -> de_o=0, hs_o=1, vs_o=0 in the same cycle (asynchronously); after release, no output until enable.
REQ-042 With VIDEO_TIMING_GEN_FRAME_CNT_EN defined and pattern=1 over two frames -> frame 1 starts with do_o=1 and frame_cnt=1.

Source files
------------

// File: rtl/video_timing_gen.sv
// Raster timing generator with built-in test patterns (constant, ramps, 8x8 checkerboard).
// Define VIDEO_TIMING_GEN_FRAME_CNT_EN to add a frame counter output that scrolls the ramps.
module video_timing_gen #(
   parameter int DE_O_PERIOD    = 0,
   parameter int LINE_SIZE_MAX  = 1024,
   parameter int LINE_COUNT_MAX = 1024,
   parameter int DATA_WIDTH     = 12
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                enable,
   input  logic [$clog2(LINE_SIZE_MAX+1)-1:0]  pix_count,
   input  logic [$clog2(LINE_COUNT_MAX+1)-1:0] line_count,
   input  logic [15:0]                         hblank,
   input  logic [15:0]                         vblank,
   input  logic [1:0]                          pattern,
   input  logic [DATA_WIDTH-1:0]               const_val,
   output logic [DATA_WIDTH-1:0]               do_o,
   output logic                                de_o,
   output logic                                hs_o,
   output logic                                vs_o,
`ifdef VIDEO_TIMING_GEN_FRAME_CNT_EN
   output logic [15:0]                         frame_cnt,
`endif
   output logic                                busy
);
   localparam int PW  = $clog2(LINE_SIZE_MAX+1);
   localparam int LW  = $clog2(LINE_COUNT_MAX+1);
   localparam int PER = (DE_O_PERIOD > 1) ? DE_O_PERIOD : 1;
   localparam int SW  = (PER > 1) ? $clog2(PER) : 1;
   localparam logic [PW-1:0] P_ONE = PW'(1);
   localparam logic [LW-1:0] L_ONE = LW'(1);
   localparam logic [SW-1:0] S_ONE = SW'(1);
   localparam logic [SW-1:0] S_LAST = SW'(PER-1);

   typedef enum logic [1:0] {IDLE, ACTIVE, HBLANK, VBLANK} state_t;

   state_t                state_q, state_d;
   logic [PW-1:0]         pix_q, pix_d, pixl_q, pixl_d;
   logic [LW-1:0]         line_q, line_d, linel_q, linel_d;
   logic [SW-1:0]         sub_q, sub_d;
   logic [15:0]           blank_q, blank_d, hbl_q, hbl_d, vbl_q, vbl_d;
   logic [1:0]            pat_q, pat_d;
   logic [DATA_WIDTH-1:0] cv_q, cv_d, do_q, do_d;
   logic                  de_q, de_d, hs_q, hs_d, vs_q, vs_d, busy_q, busy_d;
   logic                  load;
   logic [31:0]           ofs;

`ifdef VIDEO_TIMING_GEN_FRAME_CNT_EN
   logic [15:0] fc_q, fc_d;
   assign ofs       = 32'(fc_q);
   assign frame_cnt = fc_q;
`else
   assign ofs = 32'd0;
`endif

   function automatic logic [DATA_WIDTH-1:0] pix_value(input logic [1:0] sel, input logic [31:0] x,
                                                       input logic [31:0] y, input logic [31:0] o,
                                                       input logic [DATA_WIDTH-1:0] cv);
      case (sel)
         2'd0:    return cv;
         2'd1:    return DATA_WIDTH'(x + o);
         2'd2:    return DATA_WIDTH'(y + o);
         default: return (((x ^ y) & 32'd8) != 32'd0) ? '1 : '0;
      endcase
   endfunction

   always_comb begin
      state_d = state_q;
      pix_d   = pix_q;
      line_d  = line_q;
      sub_d   = sub_q;
      blank_d = blank_q;
      pixl_d  = pixl_q;
      linel_d = linel_q;
      hbl_d   = hbl_q;
      vbl_d   = vbl_q;
      pat_d   = pat_q;
      cv_d    = cv_q;
      load    = 1'b0;
`ifdef VIDEO_TIMING_GEN_FRAME_CNT_EN
      fc_d    = fc_q;
`endif
      case (state_q)
         IDLE: begin
            if (enable) begin
               state_d = ACTIVE;
               load    = 1'b1;
            end
         end
         ACTIVE: begin
            if (sub_q == S_LAST) begin
               sub_d = '0;
               if (pix_q == pixl_q - P_ONE) begin
                  pix_d   = '0;
                  blank_d = '0;
                  state_d = HBLANK;
               end else begin
                  pix_d = pix_q + P_ONE;
               end
            end else begin
               sub_d = sub_q + S_ONE;
            end
         end
         HBLANK: begin
            if (blank_q == hbl_q - 16'd1) begin
               blank_d = '0;
               if (line_q == linel_q - L_ONE) begin
                  line_d  = '0;
                  state_d = VBLANK;
               end else begin
                  line_d  = line_q + L_ONE;
                  state_d = ACTIVE;
               end
            end else begin
               blank_d = blank_q + 16'd1;
            end
         end
         default: begin
            if (blank_q == vbl_q - 16'd1) begin
               blank_d = '0;
`ifdef VIDEO_TIMING_GEN_FRAME_CNT_EN
               fc_d    = fc_q + 16'd1;
`endif
               if (enable) begin
                  state_d = ACTIVE;
                  load    = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               blank_d = blank_q + 16'd1;
            end
         end
      endcase
      // Zero-valued geometry is promoted to 1 so every counter has a reachable terminal value.
      if (load) begin
         pixl_d  = (pix_count == '0) ? P_ONE : pix_count;
         linel_d = (line_count == '0) ? L_ONE : line_count;
         hbl_d   = (hblank == 16'd0) ? 16'd1 : hblank;
         vbl_d   = (vblank == 16'd0) ? 16'd1 : vblank;
         pat_d   = pattern;
         cv_d    = const_val;
      end
      de_d   = (state_q == ACTIVE) && (sub_q == '0);
      hs_d   = (state_q != ACTIVE);
      vs_d   = (state_q == ACTIVE) || (state_q == HBLANK);
      busy_d = (state_q != IDLE);
      do_d   = de_d ? pix_value(pat_q, 32'(pix_q), 32'(line_q), ofs, cv_q) : do_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         pix_q   <= '0;
         line_q  <= '0;
         sub_q   <= '0;
         blank_q <= '0;
         pixl_q  <= '0;
         linel_q <= '0;
         hbl_q   <= '0;
         vbl_q   <= '0;
         pat_q   <= '0;
         cv_q    <= '0;
         do_q    <= '0;
         de_q    <= 1'b0;
         hs_q    <= 1'b1;
         vs_q    <= 1'b0;
         busy_q  <= 1'b0;
`ifdef VIDEO_TIMING_GEN_FRAME_CNT_EN
         fc_q    <= '0;
`endif
      end else begin
         state_q <= state_d;
         pix_q   <= pix_d;
         line_q  <= line_d;
         sub_q   <= sub_d;
         blank_q <= blank_d;
         pixl_q  <= pixl_d;
         linel_q <= linel_d;
         hbl_q   <= hbl_d;
         vbl_q   <= vbl_d;
         pat_q   <= pat_d;
         cv_q    <= cv_d;
         do_q    <= do_d;
         de_q    <= de_d;
         hs_q    <= hs_d;
         vs_q    <= vs_d;
         busy_q  <= busy_d;
`ifdef VIDEO_TIMING_GEN_FRAME_CNT_EN
         fc_q    <= fc_d;
`endif
      end
   end

   assign do_o = do_q;
   assign de_o = de_q;
   assign hs_o = hs_q;
   assign vs_o = vs_q;
   assign busy = busy_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: two instances (DE_O_PERIOD 0 and 4) against a frame-arithmetic model.
module tb_video_timing_gen;
   localparam int DW   = 12;
   localparam int DMAX = (1 << DW) - 1;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          enable = 1'b0;
   logic [10:0]   pix_count = '0;
   logic [10:0]   line_count = '0;
   logic [15:0]   hblank = '0;
   logic [15:0]   vblank = '0;
   logic [1:0]    pattern = '0;
   logic [DW-1:0] const_val = '0;

   logic [DW-1:0] do0, do4;
   logic          de0, de4, hs0, hs4, vs0, vs4, busy0, busy4;
`ifdef VIDEO_TIMING_GEN_FRAME_CNT_EN
   logic [15:0]   fcnt0, fcnt4;
`endif

   video_timing_gen #(.DE_O_PERIOD(0)) dut0 (
      .clk(clk), .rst(rst), .enable(enable), .pix_count(pix_count), .line_count(line_count),
      .hblank(hblank), .vblank(vblank), .pattern(pattern), .const_val(const_val),
      .do_o(do0), .de_o(de0), .hs_o(hs0), .vs_o(vs0),
`ifdef VIDEO_TIMING_GEN_FRAME_CNT_EN
      .frame_cnt(fcnt0),
`endif
      .busy(busy0));

   video_timing_gen #(.DE_O_PERIOD(4)) dut4 (
      .clk(clk), .rst(rst), .enable(enable), .pix_count(pix_count), .line_count(line_count),
      .hblank(hblank), .vblank(vblank), .pattern(pattern), .const_val(const_val),
      .do_o(do4), .de_o(de4), .hs_o(hs4), .vs_o(vs4),
`ifdef VIDEO_TIMING_GEN_FRAME_CNT_EN
      .frame_cnt(fcnt4),
`endif
      .busy(busy4));

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, expv);
      end
   endtask

   // ---------------- behavioural model: position within a frame from elapsed time ----------------
   int per_k [2] = '{1, 4};
   bit run_m [2];
   int t_m [2];
   int mp [2], ml [2], mh [2], mv [2], mpt [2], mcv [2], fc_m [2];
   bit exp_de [2], exp_hs [2], exp_vs [2], exp_busy [2];
   int exp_do [2];

   function automatic int patf(int sel, int x, int y, int fc, int cv);
      case (sel)
         0:       return cv;
         1:       return (x + fc) % (DMAX + 1);
         2:       return (y + fc) % (DMAX + 1);
         default: return (((x / 8) + (y / 8)) % 2 == 1) ? DMAX : 0;
      endcase
   endfunction

   task automatic latch_params(input int k);
      mp[k]  = (pix_count == 0) ? 1 : int'(pix_count);
      ml[k]  = (line_count == 0) ? 1 : int'(line_count);
      mh[k]  = (hblank == 0) ? 1 : int'(hblank);
      mv[k]  = (vblank == 0) ? 1 : int'(vblank);
      mpt[k] = int'(pattern);
      mcv[k] = int'(const_val);
      t_m[k] = 0;
   endtask

   task automatic model_step();
      int al, ll, fa, tot, r;
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            run_m[k] = 0; t_m[k] = 0; fc_m[k] = 0;
            exp_de[k] = 0; exp_hs[k] = 1; exp_vs[k] = 0; exp_busy[k] = 0; exp_do[k] = 0;
         end else if (!run_m[k]) begin
            exp_de[k] = 0; exp_hs[k] = 1; exp_vs[k] = 0; exp_busy[k] = 0;
            if (enable) begin
               latch_params(k);
               run_m[k] = 1;
            end
         end else begin
            al  = mp[k] * per_k[k];
            ll  = al + mh[k];
            fa  = ml[k] * ll;
            tot = fa + mv[k];
            exp_busy[k] = 1; exp_de[k] = 0; exp_hs[k] = 1; exp_vs[k] = 0;
            if (t_m[k] < fa) begin
               r = t_m[k] % ll;
               exp_vs[k] = 1;
               if (r < al) begin
                  exp_hs[k] = 0;
                  if (r % per_k[k] == 0) begin
                     exp_de[k] = 1;
                     exp_do[k] = patf(mpt[k], r / per_k[k], t_m[k] / ll, fc_m[k], mcv[k]);
                  end
               end
            end
            if (t_m[k] == tot - 1) begin
`ifdef VIDEO_TIMING_GEN_FRAME_CNT_EN
               fc_m[k] = (fc_m[k] + 1) % 65536;
`endif
               if (enable) latch_params(k);
               else run_m[k] = 0;
            end else begin
               t_m[k]++;
            end
         end
      end
   endtask

   initial forever begin
      @(posedge clk or posedge rst);
      model_step();
   end

   // ---------------- per-cycle compare ----------------
   bit chk_on = 0;
   initial forever begin
      @(negedge clk);
      if (chk_on) begin
         chk("de_o[p0]", 32'(de0), 32'(exp_de[0]));
         chk("hs_o[p0]", 32'(hs0), 32'(exp_hs[0]));
         chk("vs_o[p0]", 32'(vs0), 32'(exp_vs[0]));
         chk("busy[p0]", 32'(busy0), 32'(exp_busy[0]));
         chk("do_o[p0]", 32'(do0), 32'(exp_do[0]));
         chk("de_o[p4]", 32'(de4), 32'(exp_de[1]));
         chk("hs_o[p4]", 32'(hs4), 32'(exp_hs[1]));
         chk("vs_o[p4]", 32'(vs4), 32'(exp_vs[1]));
         chk("busy[p4]", 32'(busy4), 32'(exp_busy[1]));
         chk("do_o[p4]", 32'(do4), 32'(exp_do[1]));
`ifdef VIDEO_TIMING_GEN_FRAME_CNT_EN
         chk("frame_cnt[p0]", 32'(fcnt0), 32'(fc_m[0]));
         chk("frame_cnt[p4]", 32'(fcnt4), 32'(fc_m[1]));
`endif
      end
   end

   // ---------------- directed frame capture ----------------
   bit rec_de [2][1200];
   bit rec_hs [2][1200];
   bit rec_vs [2][1200];
   int rec_do [2][1200];
   int rec_fc0 = 0;
   int frames_done = 0;

   task automatic wait_idle();
      int c = 0;
      while ((busy0 || busy4) && c < 5000) begin
         @(negedge clk);
         c++;
      end
      chk("idle_after_frame", {30'd0, busy0, busy4}, 32'd0);
   endtask

   task automatic run_frame(input int pc, input int lc, input int hb, input int vb, input int pt,
                            input int cv, input int n, input int drop_at, input bit scramble);
      @(negedge clk);
      pix_count = 11'(pc); line_count = 11'(lc); hblank = 16'(hb); vblank = 16'(vb);
      pattern = 2'(pt); const_val = DW'(cv); enable = 1'b1;
      @(negedge clk);
      if (drop_at == 0) enable = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         rec_de[0][i] = de0; rec_hs[0][i] = hs0; rec_vs[0][i] = vs0; rec_do[0][i] = int'(do0);
         rec_de[1][i] = de4; rec_hs[1][i] = hs4; rec_vs[1][i] = vs4; rec_do[1][i] = int'(do4);
`ifdef VIDEO_TIMING_GEN_FRAME_CNT_EN
         if (i == 0) rec_fc0 = int'(fcnt0);
`endif
         if (i + 1 == drop_at) enable = 1'b0;
         if (scramble && i == 5) begin
            pix_count = 11'd9; line_count = 11'd1; pattern = 2'd0; hblank = 16'd7;
         end
      end
      wait_idle();
      frames_done++;
   endtask

   initial begin
      int vs_cnt, hs_cnt, npx, off;
      int px [300];
      bit rel;
      #1 rst = 1'b1;
      chk_on = 1;
      repeat (3) @(negedge clk);
      chk("reset_de", 32'(de0), 32'd0);
      chk("reset_hs", 32'(hs0), 32'd1);
      chk("reset_vs", 32'(vs0), 32'd0);
      chk("reset_busy", 32'(busy4), 32'd0);
      chk("reset_do", 32'(do0), 32'd0);
`ifdef VIDEO_TIMING_GEN_FRAME_CNT_EN
      chk("reset_frame_cnt", 32'(fcnt0), 32'd0);
`endif
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // A: 4x3 horizontal ramp, enable dropped during line 1, inputs scrambled mid-frame
      run_frame(4, 3, 2, 3, 1, 0, 40, 8, 1);
      vs_cnt = 0; hs_cnt = 0; npx = 0;
      for (int i = 0; i < 40; i++) begin
         if (rec_vs[0][i]) vs_cnt++;
         if (!rec_hs[0][i]) hs_cnt++;
         if (rec_de[0][i]) begin
            chk("A_ramp_value", 32'(rec_do[0][i]), 32'(npx % 4));
            npx++;
         end
      end
      chk("A_vs_cycles", 32'(vs_cnt), 32'd18);
      chk("A_hs_low_cycles", 32'(hs_cnt), 32'd12);
      chk("A_pixel_count", 32'(npx), 32'd12);
      chk("A_de_contig", {28'd0, rec_de[0][0], rec_de[0][1], rec_de[0][2], rec_de[0][3]}, 32'hF);
      chk("A_hs_after_line", 32'(rec_hs[0][4]), 32'd1);
      chk("A_line1_start_de", 32'(rec_de[0][6]), 32'd1);

`ifdef VIDEO_TIMING_GEN_FRAME_CNT_EN
      // A2: second ramp frame scrolls by one
      run_frame(4, 3, 2, 3, 1, 0, 40, 0, 0);
      chk("A2_first_pixel", 32'(rec_do[0][0]), 32'd1);
      chk("A2_frame_cnt", 32'(rec_fc0), 32'd1);
      off = frames_done;
`else
      off = 0;
`endif

      // B: period-4 vertical ramp, pix=3
      run_frame(3, 2, 1, 1, 2, 0, 30, 0, 0);
      for (int i = 0; i < 12; i++) begin
         chk("B_de_period", 32'(rec_de[1][i]), 32'(i % 4 == 0));
         chk("B_hs_active", 32'(rec_hs[1][i]), 32'd0);
      end
      chk("B_hs_hblank", 32'(rec_hs[1][12]), 32'd1);
      chk("B_line0_value", 32'(rec_do[1][0]), 32'(off % (DMAX + 1)));
      chk("B_hold_value", 32'(rec_do[1][5]), 32'(off % (DMAX + 1)));
      chk("B_line1_de", 32'(rec_de[1][13]), 32'd1);
      chk("B_line1_value", 32'(rec_do[1][13]), 32'((off + 1) % (DMAX + 1)));

      // C: checkerboard 16x16
      run_frame(16, 16, 1, 1, 3, 0, 300, 0, 0);
      npx = 0;
      for (int i = 0; i < 300; i++)
         if (rec_de[0][i]) begin px[npx] = rec_do[0][i]; npx++; end
      chk("C_pixel_count", 32'(npx), 32'd256);
      chk("C_px_8_0", 32'(px[8]), 32'(DMAX));
      chk("C_px_8_8", 32'(px[136]), 32'd0);
      chk("C_px_0_0", 32'(px[0]), 32'd0);
      chk("C_px_0_8", 32'(px[128]), 32'(DMAX));

      // E: all-zero geometry behaves as 1x1 with single-cycle blanks
      run_frame(0, 0, 0, 0, 0, 'h5A5, 6, 0, 0);
      chk("E_de", 32'(rec_de[0][0]), 32'd1);
      chk("E_const", 32'(rec_do[0][0]), 32'h5A5);
      chk("E_hblank_vs", {30'd0, rec_de[0][1], rec_vs[0][1]}, 32'd1);
      chk("E_vblank_vs", 32'(rec_vs[0][2]), 32'd0);

      // D: asynchronous reset in the middle of an active line
      @(negedge clk);
      pix_count = 11'd16; line_count = 11'd4; hblank = 16'd2; vblank = 16'd2;
      pattern = 2'd1; enable = 1'b1;
      repeat (4) @(negedge clk);
      chk("D_pre_reset_de", 32'(de0), 32'd1);
      chk("D_pre_reset_vs", 32'(vs4), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("D_async_de", {30'd0, de0, de4}, 32'd0);
      chk("D_async_hs", {30'd0, hs0, hs4}, 32'd3);
      chk("D_async_vs", {30'd0, vs0, vs4}, 32'd0);
      @(negedge clk);
      rst = 1'b0; enable = 1'b0;
      repeat (10) @(negedge clk);
      chk("D_no_output_de", {30'd0, de0, de4}, 32'd0);
      chk("D_no_output_busy", {30'd0, busy0, busy4}, 32'd0);

      // R: randomized traffic with mid-frame parameter changes and occasional async resets
      rel = 0;
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         if (rel) begin rst = 1'b0; rel = 0; end
         enable = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 7) == 0) begin
            pix_count  = 11'($urandom_range(0, 20));
            line_count = 11'($urandom_range(0, 5));
            hblank     = 16'($urandom_range(0, 4));
            vblank     = 16'($urandom_range(0, 4));
            pattern    = 2'($urandom_range(0, 3));
            const_val  = DW'($urandom);
         end
         if ($urandom_range(0, 599) == 0) begin
            #2 rst = 1'b1;
            #1;
            chk("R_async_de", {30'd0, de0, de4}, 32'd0);
            chk("R_async_vs", {30'd0, vs0, vs4}, 32'd0);
            rel = 1;
         end
      end
      rst = 1'b0;
      @(negedge clk);
      chk_on = 0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
